// File: rtl/frv_masked_bitwise_seq.sv
// Issue/retire sequencer for the masked bitwise unit: latches a two-share request and fresh
// randomness, drives the unit from registers, captures the selected result and hands it back.
module frv_masked_bitwise_seq #(
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [1:0]             i_op,
    input  logic [BIT_WIDTH-1:0]   i_a0,
    input  logic [BIT_WIDTH-1:0]   i_a1,
    input  logic [BIT_WIDTH-1:0]   i_b0,
    input  logic [BIT_WIDTH-1:0]   i_b1,
    input  logic                   rng_valid,
    output logic                   rng_ack,
    input  logic [4*BIT_WIDTH-1:0] rng_z,
    output logic                   bw_ena,
    output logic [BIT_WIDTH-1:0]   bw_remask0,
    output logic [BIT_WIDTH-1:0]   bw_remask1,
    output logic [BIT_WIDTH-1:0]   bw_remask2,
    output logic [BIT_WIDTH-1:0]   bw_remask3,
    output logic [BIT_WIDTH-1:0]   bw_a0,
    output logic [BIT_WIDTH-1:0]   bw_a1,
    output logic [BIT_WIDTH-1:0]   bw_b0,
    output logic [BIT_WIDTH-1:0]   bw_b1,
    input  logic                   bw_rdy,
    input  logic [BIT_WIDTH-1:0]   bw_and0,
    input  logic [BIT_WIDTH-1:0]   bw_and1,
    input  logic [BIT_WIDTH-1:0]   bw_xor0,
    input  logic [BIT_WIDTH-1:0]   bw_xor1,
    input  logic [BIT_WIDTH-1:0]   bw_ior0,
    input  logic [BIT_WIDTH-1:0]   bw_ior1,
    input  logic [BIT_WIDTH-1:0]   bw_not0,
    input  logic [BIT_WIDTH-1:0]   bw_not1,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [BIT_WIDTH-1:0]   o_r0,
    output logic [BIT_WIDTH-1:0]   o_r1,
    output logic                   busy
);

    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpIor = 2'b01;
    localparam logic [1:0] OpXor = 2'b10;
    localparam logic [1:0] OpNot = 2'b11;

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0]           op_q, op_d;
    logic [BIT_WIDTH-1:0] a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
    logic [BIT_WIDTH-1:0] z0_q, z0_d, z1_q, z1_d, z2_q, z2_d, z3_q, z3_d;
    logic [BIT_WIDTH-1:0] r0_q, r0_d, r1_q, r1_d;

    logic accept, rng_take, capture, retire;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (i_valid)   state_d = StLoad;
            StLoad: if (rng_valid) state_d = StExec;
            StExec: if (bw_rdy)    state_d = StDone;
            StDone: if (i_ready)   state_d = StIdle;
            default:               state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        o_ready  = (state_q == StIdle) & ~flush;
        rng_ack  = (state_q == StLoad) & rng_valid & ~flush;
        bw_ena   = (state_q == StExec);
        o_valid  = (state_q == StDone);
        busy     = (state_q != StIdle);
        accept   = i_valid & o_ready;
        rng_take = rng_ack;
        capture  = (state_q == StExec) & bw_rdy & ~flush;
        retire   = o_valid & i_ready & ~flush;
    end

    // IOR is computed by the unit as ~(~a & ~b), so the second shares are inverted at latch time.
    always_comb begin
        op_d = op_q;
        a0_d = a0_q;
        a1_d = a1_q;
        b0_d = b0_q;
        b1_d = b1_q;
        z0_d = z0_q;
        z1_d = z1_q;
        z2_d = z2_q;
        z3_d = z3_q;
        r0_d = r0_q;
        r1_d = r1_q;
        if (flush || retire) begin
            op_d = '0;
            a0_d = '0;
            a1_d = '0;
            b0_d = '0;
            b1_d = '0;
            z0_d = '0;
            z1_d = '0;
            z2_d = '0;
            z3_d = '0;
            r0_d = '0;
            r1_d = '0;
        end else begin
            if (accept) begin
                op_d = i_op;
                a0_d = i_a0;
                b0_d = i_b0;
                a1_d = (i_op == OpIor) ? ~i_a1 : i_a1;
                b1_d = (i_op == OpIor) ? ~i_b1 : i_b1;
            end
            if (rng_take) begin
                z0_d = rng_z[0*BIT_WIDTH +: BIT_WIDTH];
                z1_d = rng_z[1*BIT_WIDTH +: BIT_WIDTH];
                z2_d = rng_z[2*BIT_WIDTH +: BIT_WIDTH];
                z3_d = rng_z[3*BIT_WIDTH +: BIT_WIDTH];
            end
            if (capture) begin
                unique case (op_q)
                    OpAnd: begin r0_d = bw_and0; r1_d = bw_and1; end
                    OpIor: begin r0_d = bw_ior0; r1_d = bw_ior1; end
                    OpXor: begin r0_d = bw_xor0; r1_d = bw_xor1; end
                    OpNot: begin r0_d = bw_not0; r1_d = bw_not1; end
                    default: begin r0_d = '0; r1_d = '0; end
                endcase
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            op_q <= '0;
            a0_q <= '0;
            a1_q <= '0;
            b0_q <= '0;
            b1_q <= '0;
            z0_q <= '0;
            z1_q <= '0;
            z2_q <= '0;
            z3_q <= '0;
            r0_q <= '0;
            r1_q <= '0;
        end else begin
            op_q <= op_d;
            a0_q <= a0_d;
            a1_q <= a1_d;
            b0_q <= b0_d;
            b1_q <= b1_d;
            z0_q <= z0_d;
            z1_q <= z1_d;
            z2_q <= z2_d;
            z3_q <= z3_d;
            r0_q <= r0_d;
            r1_q <= r1_d;
        end
    end

    assign bw_a0      = a0_q;
    assign bw_a1      = a1_q;
    assign bw_b0      = b0_q;
    assign bw_b1      = b1_q;
    assign bw_remask0 = z0_q;
    assign bw_remask1 = z1_q;
    assign bw_remask2 = z2_q;
    assign bw_remask3 = z3_q;
    assign o_r0       = r0_q;
    assign o_r1       = r1_q;

endmodule

// File: tb/tb_frv_masked_bitwise_seq.sv
// Bench for frv_masked_bitwise_seq: behavioural masked unit, scoreboard of unmasked results.
module tb_frv_masked_bitwise_seq;

    localparam int unsigned W = 32;
    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpIor = 2'b01;
    localparam logic [1:0] OpXor = 2'b10;
    localparam logic [1:0] OpNot = 2'b11;

    logic           g_clk = 1'b0;
    logic           g_resetn = 1'b0;
    logic           flush = 1'b0;
    logic           i_valid = 1'b0;
    logic           o_ready;
    logic [1:0]     i_op = '0;
    logic [W-1:0]   i_a0 = '0, i_a1 = '0, i_b0 = '0, i_b1 = '0;
    logic           rng_valid = 1'b0;
    logic           rng_ack;
    logic [4*W-1:0] rng_z = '0;
    logic           bw_ena;
    logic [W-1:0]   bw_remask0, bw_remask1, bw_remask2, bw_remask3;
    logic [W-1:0]   bw_a0, bw_a1, bw_b0, bw_b1;
    logic           bw_rdy;
    logic [W-1:0]   bw_and0, bw_and1, bw_xor0, bw_xor1, bw_ior0, bw_ior1, bw_not0, bw_not1;
    logic           o_valid;
    logic           i_ready = 1'b0;
    logic [W-1:0]   o_r0, o_r1;
    logic           busy;

    logic           unit_rdy;
    logic           rdy_glitch = 1'b0;
    logic [W-1:0]   ua, ub;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [W-1:0]   exp_q[$];
    logic [1:0]     cur_op;
    logic [W-1:0]   cur_a, cur_b;

    frv_masked_bitwise_seq #(.BIT_WIDTH(W)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
        .i_a0(i_a0), .i_a1(i_a1), .i_b0(i_b0), .i_b1(i_b1),
        .rng_valid(rng_valid), .rng_ack(rng_ack), .rng_z(rng_z),
        .bw_ena(bw_ena),
        .bw_remask0(bw_remask0), .bw_remask1(bw_remask1),
        .bw_remask2(bw_remask2), .bw_remask3(bw_remask3),
        .bw_a0(bw_a0), .bw_a1(bw_a1), .bw_b0(bw_b0), .bw_b1(bw_b1),
        .bw_rdy(bw_rdy),
        .bw_and0(bw_and0), .bw_and1(bw_and1), .bw_xor0(bw_xor0), .bw_xor1(bw_xor1),
        .bw_ior0(bw_ior0), .bw_ior1(bw_ior1), .bw_not0(bw_not0), .bw_not1(bw_not1),
        .o_valid(o_valid), .i_ready(i_ready), .o_r0(o_r0), .o_r1(o_r1), .busy(busy)
    );

    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) rng_z <= {$urandom, $urandom, $urandom, $urandom};

    // Behavioural masked unit: one cycle after seeing bw_ena it presents remasked results.
    assign ua     = bw_a0 ^ bw_a1;
    assign ub     = bw_b0 ^ bw_b1;
    assign bw_rdy = unit_rdy | rdy_glitch;

    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            unit_rdy <= 1'b0;
            bw_and0 <= '0; bw_and1 <= '0; bw_xor0 <= '0; bw_xor1 <= '0;
            bw_ior0 <= '0; bw_ior1 <= '0; bw_not0 <= '0; bw_not1 <= '0;
        end else begin
            unit_rdy <= bw_ena & ~unit_rdy;
            if (bw_ena && !unit_rdy) begin
                bw_and0 <= bw_remask0; bw_and1 <= bw_remask0 ^ (ua & ub);
                bw_xor0 <= bw_remask1; bw_xor1 <= bw_remask1 ^ (ua ^ ub);
                bw_ior0 <= bw_remask2; bw_ior1 <= bw_remask2 ^ ~(ua & ub);
                bw_not0 <= bw_remask3; bw_not1 <= bw_remask3 ^ ~ua;
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            OpAnd:   return a & b;
            OpIor:   return a | b;
            OpXor:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Scoreboard: push on accept, pop and compare on result handshake.
    always @(negedge g_clk) begin
        if (g_resetn && !flush) begin
            if (i_valid && o_ready) exp_q.push_back(model(cur_op, cur_a, cur_b));
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check("spurious_result", 32'd1, 32'd0);
                else check("result", o_r0 ^ o_r1, exp_q.pop_front());
            end
        end
    end

    task automatic check_idle_clean(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_o_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_bw_ena"}, 32'(bw_ena), 32'd0);
        check({tag, "_bw_ops"}, bw_a0 | bw_a1 | bw_b0 | bw_b1, 32'd0);
        check({tag, "_bw_z"}, bw_remask0 | bw_remask1 | bw_remask2 | bw_remask3, 32'd0);
        check({tag, "_o_r"}, o_r0 | o_r1, 32'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int waited);
        cur_op = op; cur_a = a; cur_b = b;
        i_op = op;
        i_a0 = $urandom; i_a1 = i_a0 ^ a;
        i_b0 = $urandom; i_b1 = i_b0 ^ b;
        i_valid = 1'b1;
        waited = 0;
        @(negedge g_clk);
        while (!o_ready && waited < 50) begin
            @(negedge g_clk);
            waited++;
        end
        check("accept_seen", 32'(o_ready), 32'd1);
        @(posedge g_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int rng_wait, input int rdy_wait, input bit keep,
                          output int waited);
        int         cycles;
        int         acks;
        logic       ena_early;
        logic [W-1:0] sa1, sb1, r0s, r1s;
        issue(op, a, b, waited);
        cycles = 0; acks = 0; ena_early = 1'b0; sa1 = '0; sb1 = '0;
        while (!o_valid && cycles < 60) begin
            rng_valid  = (cycles >= rng_wait);
            rdy_glitch = (cycles < rng_wait);
            @(negedge g_clk);
            if (rng_ack) acks++;
            if (cycles < rng_wait && bw_ena) ena_early = 1'b1;
            if (bw_ena) begin sa1 = bw_a1; sb1 = bw_b1; end
            @(posedge g_clk); #1;
            cycles++;
        end
        rdy_glitch = 1'b0;
        check("latency", cycles, 3 + rng_wait);
        check("rng_ack_pulses", acks, 32'd1);
        check("ena_in_load", 32'(ena_early), 32'd0);
        check("bw_a1_share", sa1, (op == OpIor) ? ~i_a1 : i_a1);
        check("bw_b1_share", sb1, (op == OpIor) ? ~i_b1 : i_b1);
        r0s = o_r0; r1s = o_r1;
        if (keep) i_valid = 1'b1;
        for (int k = 0; k < rdy_wait; k++) begin
            @(negedge g_clk);
            check("r0_stable", o_r0, r0s);
            check("r1_stable", o_r1, r1s);
            check("o_ready_in_done", 32'(o_ready), 32'd0);
            check("o_valid_held", 32'(o_valid), 32'd1);
            @(posedge g_clk); #1;
        end
        i_ready = 1'b1;
        @(negedge g_clk);
        @(posedge g_clk); #1;
        i_ready = 1'b0;
        check("retire_o_valid", 32'(o_valid), 32'd0);
        check("retire_o_r", o_r0 | o_r1, 32'd0);
        check("retire_bw_ops", bw_a0 | bw_a1 | bw_b0 | bw_b1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        #1;
        check("reset_o_ready", 32'(o_ready), 32'd1);
        check("reset_rng_ack", 32'(rng_ack), 32'd0);
        check_idle_clean("reset");
        repeat (2) @(posedge g_clk);
        #1 g_resetn = 1'b1;
        @(posedge g_clk); #1;

        run_op(OpAnd, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1'b0, w);
        run_op(OpIor, 32'h0000FFFF, 32'h00FF0000, 0, 0, 1'b0, w);
        run_op(OpXor, 32'hAAAAAAAA, 32'h55555555, 0, 0, 1'b0, w);
        run_op(OpNot, 32'hAAAAAAAA, 32'h55555555, 0, 0, 1'b0, w);
        run_op(OpAnd, $urandom, $urandom, 5, 0, 1'b0, w);
        run_op(OpXor, $urandom, $urandom, 0, 4, 1'b1, w);
        run_op(OpIor, $urandom, $urandom, 0, 0, 1'b0, w);
        check("held_request_taken_after_retire", w, 32'd0);

        // Flush while the unit is running.
        rng_valid = 1'b1;
        issue(OpXor, $urandom, $urandom, w);
        @(posedge g_clk); #1;
        check("exec_bw_ena", 32'(bw_ena), 32'd1);
        flush = 1'b1;
        @(posedge g_clk); #1;
        flush = 1'b0;
        exp_q.delete();
        check_idle_clean("flush_exec");
        i_ready = 1'b1;
        repeat (4) @(posedge g_clk);
        #1;
        check("flush_no_result", 32'(o_valid), 32'd0);
        i_ready = 1'b0;

        // Flush in LOAD must mask rng_ack; flush in IDLE must mask o_ready.
        issue(OpAnd, $urandom, $urandom, w);
        flush = 1'b1;
        @(negedge g_clk);
        check("flush_rng_ack", 32'(rng_ack), 32'd0);
        @(posedge g_clk); #1;
        exp_q.delete();
        check_idle_clean("flush_load");
        i_valid = 1'b1;
        @(negedge g_clk);
        check("flush_o_ready", 32'(o_ready), 32'd0);
        @(posedge g_clk); #1;
        i_valid = 1'b0;
        flush = 1'b0;
        check("flush_no_accept", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of LOAD.
        rng_valid = 1'b0;
        issue(OpAnd, $urandom, $urandom, w);
        #2 g_resetn = 1'b0;
        #1;
        exp_q.delete();
        check_idle_clean("reset_load");
        check("reset_load_o_ready", 32'(o_ready), 32'd1);
        @(posedge g_clk); #1 g_resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 2), 1'b0, w);
        end

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
